// File: rtl/dice_pkg.sv
// Shared constants and state type for the dice 7-segment receive path.
// Segment order is bit6=a .. bit0=g, 1 = lit.
package dice_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_FACE1 = 7'b0110000;
    localparam logic [6:0] SEG_FACE2 = 7'b1101101;
    localparam logic [6:0] SEG_FACE3 = 7'b1111001;
    localparam logic [6:0] SEG_FACE4 = 7'b0110011;
    localparam logic [6:0] SEG_FACE5 = 7'b1011011;
    localparam logic [6:0] SEG_FACE6 = 7'b1011111;

    localparam logic [2:0] FACE_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } dec_state_t;
endpackage

// File: rtl/dice_seg_lut.sv
// Combinational segment-pattern to dice-face lookup; reused by display checkers.
module dice_seg_lut
    import dice_pkg::*;
(
    input  logic [6:0] seg,
    output logic [2:0] face,
    output logic       is_valid,
    output logic       is_blank
);
    always_comb begin
        face     = FACE_NONE;
        is_valid = 1'b1;
        is_blank = 1'b0;
        case (seg)
            SEG_FACE1: face = 3'd1;
            SEG_FACE2: face = 3'd2;
            SEG_FACE3: face = 3'd3;
            SEG_FACE4: face = 3'd4;
            SEG_FACE5: face = 3'd5;
            SEG_FACE6: face = 3'd6;
            SEG_BLANK: begin
                is_valid = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/dice_seg_decoder.sv
// Dice 7-segment receiver: stability filter, face decode, one-cycle result pulses.
// Define DICE_HIST_EN to build the per-face roll histogram.
module dice_seg_decoder
    import dice_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    output logic [2:0]       face,
    output logic             face_valid,
    output logic             invalid_err,
    input  logic [2:0]       hist_sel,
    input  logic             hist_clr,
    output logic [CNT_W-1:0] hist_cnt
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    dec_state_t    state, state_n;
    logic [6:0]    seg_q, cand, cand_n, last, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    face_n;
    logic          face_valid_n, invalid_err_n;
    logic [2:0]    cand_face;
    logic          cand_valid, cand_blank;

    dice_seg_lut u_lut (
        .seg      (cand),
        .face     (cand_face),
        .is_valid (cand_valid),
        .is_blank (cand_blank)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            seg_q       <= SEG_BLANK;
            cand        <= SEG_BLANK;
            last        <= SEG_BLANK;
            cnt         <= '0;
            face        <= FACE_NONE;
            face_valid  <= 1'b0;
            invalid_err <= 1'b0;
        end else begin
            state       <= state_n;
            seg_q       <= seg_in;
            cand        <= cand_n;
            last        <= last_n;
            cnt         <= cnt_n;
            face        <= face_n;
            face_valid  <= face_valid_n;
            invalid_err <= invalid_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cand_n        = cand;
        last_n        = last;
        cnt_n         = cnt;
        face_n        = face;
        face_valid_n  = 1'b0;
        invalid_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (seg_q != SEG_BLANK) begin
                    cand_n  = seg_q;
                    cnt_n   = CW'(1);
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (seg_q != cand) begin
                    cand_n = seg_q;
                    cnt_n  = CW'(1);
                end else if (cnt + CW'(1) == CW'(STABLE_CYCLES)) begin
                    last_n = cand;
                    if (cand_valid) begin
                        face_n       = cand_face;
                        face_valid_n = 1'b1;
                        state_n      = LOCKED;
                    end else if (cand_blank) begin
                        state_n = IDLE;
                    end else begin
                        invalid_err_n = 1'b1;
                        state_n       = LOCKED;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            LOCKED: begin
                // Held pattern produces no repeat pulses; only a change re-arms the filter.
                if (seg_q != last) begin
                    cand_n  = seg_q;
                    cnt_n   = CW'(1);
                    state_n = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef DICE_HIST_EN
    logic [CNT_W-1:0] hist [6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) hist[i] <= '0;
        end else if (hist_clr) begin
            for (int i = 0; i < 6; i++) hist[i] <= '0;
        end else if (face_valid) begin
            for (int i = 0; i < 6; i++) begin
                if (face == 3'(i + 1) && hist[i] != '1) hist[i] <= hist[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        hist_cnt = '0;
        for (int i = 0; i < 6; i++) begin
            if (hist_sel == 3'(i + 1)) hist_cnt = hist[i];
        end
    end
`else
    logic unused_hist;
    assign unused_hist = ^{hist_sel, hist_clr};
    assign hist_cnt    = '0;
`endif
endmodule

// File: tb/tb_dice_seg_decoder.sv
// Scoreboard bench for dice_seg_decoder: stimulus queues expected pulses, a monitor checks them.
module tb_dice_seg_decoder;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] PB = 7'b0000000;
    localparam logic [6:0] PX = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic [2:0] face;
    logic       face_valid;
    logic       invalid_err;
    logic [2:0] hist_sel;
    logic       hist_clr;
    logic [1:0] hist_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic       inv;
        logic [2:0] face;
        int         cyc;
    } exp_t;
    exp_t expq[$];

    dice_seg_decoder #(.STABLE_CYCLES(4), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .face        (face),
        .face_valid  (face_valid),
        .invalid_err (invalid_err),
        .hist_sel    (hist_sel),
        .hist_clr    (hist_clr),
        .hist_cnt    (hist_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Pattern applied now is sampled at the next edge; pulse follows 5 edges later.
    task automatic expect_pulse(input logic inv, input logic [2:0] f);
        exp_t e;
        e.inv  = inv;
        e.face = f;
        e.cyc  = cyc + 5;
        expq.push_back(e);
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_hist(input string name, input logic [2:0] sel, input int exp);
        hist_sel = sel;
        #1;
        chk(name, int'(hist_cnt), exp);
    endtask

    always @(negedge clk) begin
        if (!rst && (face_valid || invalid_err)) begin
            exp_t e;
            checks++;
            if (face_valid && invalid_err) begin
                errors++;
                $display("FAIL both_pulses cyc=%0d", cyc);
            end else if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d face_valid=%0b invalid_err=%0b face=%0d",
                         cyc, face_valid, invalid_err, face);
            end else begin
                e = expq.pop_front();
                if (e.inv != invalid_err || e.face != face || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL pulse actual inv=%0b face=%0d cyc=%0d expected inv=%0b face=%0d cyc=%0d",
                             invalid_err, face, cyc, e.inv, e.face, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        seg_in   = PB;
        hist_sel = 3'd0;
        hist_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_face", int'(face), 0);
        chk("reset_face_valid", int'(face_valid), 0);
        chk("reset_invalid_err", int'(invalid_err), 0);
        rst = 1'b0;
        hold(PB, 2);

        // Single face, held long: exactly one pulse.
        expect_pulse(1'b0, 3'd3);
        hold(P3, 10);
        chk("face_after_3", int'(face), 3);

        // Glitch on 2 is discarded, 5 settles.
        hold(P2, 2);
        expect_pulse(1'b0, 3'd5);
        hold(P5, 8);

        // Invalid pattern keeps the previous face.
        expect_pulse(1'b1, 3'd5);
        hold(PX, 6);
        chk("face_after_invalid", int'(face), 5);

        // Same face twice separated by blank.
        expect_pulse(1'b0, 3'd1);
        hold(P1, 6);
        hold(PB, 6);
        expect_pulse(1'b0, 3'd1);
        hold(P1, 6);

        // Histogram traffic: three 6s, one 2.
        expect_pulse(1'b0, 3'd6);
        hold(P6, 6);
        expect_pulse(1'b0, 3'd2);
        hold(P2, 6);
        expect_pulse(1'b0, 3'd6);
        hold(P6, 6);
        hold(PB, 6);
        expect_pulse(1'b0, 3'd6);
        hold(P6, 6);
`ifdef DICE_HIST_EN
        read_hist("hist_6", 3'd6, 3);
        read_hist("hist_2", 3'd2, 1);
        read_hist("hist_1", 3'd1, 2);
        read_hist("hist_0", 3'd0, 0);
        read_hist("hist_7", 3'd7, 0);
`else
        read_hist("hist_off_6", 3'd6, 0);
        read_hist("hist_off_1", 3'd1, 0);
`endif
        hold(PB, 6);
        expect_pulse(1'b0, 3'd6);
        hold(P6, 6);
`ifdef DICE_HIST_EN
        read_hist("hist_6_sat", 3'd6, 3);
`endif

        // Clear coincident with a face_valid pulse.
        expect_pulse(1'b0, 3'd2);
        seg_in = P2;
        repeat (5) @(posedge clk);
        #1;
        hist_clr = 1'b1;
        @(posedge clk);
        #1;
        hist_clr = 1'b0;
        hold(P2, 2);
        for (int s = 1; s <= 6; s++) read_hist("hist_clr", 3'(s), 0);

        // Reset in the middle of SETTLE discards the candidate.
        hold(PB, 6);
        seg_in = P4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_face", int'(face), 0);
        chk("midrst_face_valid", int'(face_valid), 0);
        chk("midrst_invalid_err", int'(invalid_err), 0);
        read_hist("midrst_hist", 3'd2, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_pulse(1'b0, 3'd4);
        hold(P4, 8);
        chk("face_after_rst", int'(face), 4);

        hold(P4, 3);
        chk("pending_expected", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
